pipelined_adder: RTL

//   Parametrised, pipelined ripple-carry adder/subtractor built from segmented full-adder chains.
//   A WIDTH-bit add is split into STAGES carry segments, one segment per clock.
//   The carry is registered between segments, so the block accepts one operation per cycle.

---
 rtl/pipelined_adder.sv | 71 +++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// pipelined_adder: segmented ripple-carry adder/subtractor, one carry segment per stage, valid/ready with backpressure
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int SEG = WIDTH / STAGES;
  logic             v  [STAGES];
  logic             c  [STAGES];
  logic [WIDTH-1:0] ar [STAGES];
  logic [WIDTH-1:0] br [STAGES];
  logic [WIDTH-1:0] sr [STAGES];
  logic             adv;
  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign out_valid = v[STAGES-1];
  assign sum       = sr[STAGES-1];
  assign cout      = c[STAGES-1];
  assign ovf       = (ar[STAGES-1][WIDTH-1] == br[STAGES-1][WIDTH-1]) && (sr[STAGES-1][WIDTH-1] != ar[STAGES-1][WIDTH-1]);
  for (genvar i = 0; i < STAGES; i++) begin : g_st
    logic [WIDTH-1:0] ai, bi, si, so;
    logic             ci, vi, co;
    logic [SEG-1:0]   seg;
    if (i == 0) begin : g_in
      assign ai = a;
      assign bi = sub ? ~b : b;
      assign ci = sub | cin;
      assign si = '0;
      assign vi = in_valid;
    end else begin : g_mid
      assign ai = ar[i-1];
      assign bi = br[i-1];
      assign ci = c[i-1];
      assign si = sr[i-1];
      assign vi = v[i-1];
    end
    assign {co, seg} = {1'b0, ai[i*SEG +: SEG]} + {1'b0, bi[i*SEG +: SEG]} + {{SEG{1'b0}}, ci};
    always_comb begin
      so = si;
      so[i*SEG +: SEG] = seg;
    end
    always_ff @(posedge clk) begin
      if (rst) begin
        v[i]  <= 1'b0;
        c[i]  <= 1'b0;
        ar[i] <= '0;
        br[i] <= '0;
        sr[i] <= '0;
      end else if (adv) begin
        v[i]  <= vi;
        c[i]  <= co;
        ar[i] <= ai;
        br[i] <= bi;
        sr[i] <= so;
      end
    end
  end
endmodule
